result_formatter: RTL and testbench

RESULT_FORMATTER -- requirements
Module: result_formatter

---
 rtl/result_formatter.sv | 216 +++++++++++++++++++++
 tb/tb_result_formatter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/result_formatter.sv
// result_formatter
//   Turns a finished division (quotient, raw partial remainder, divisor)
//   into an ASCII line for a UART transmitter. The line has the form
//   "<quotient> R=<remainder>\r\n", or "ERR\r\n" when the divisor is zero.
//
// Ports
//   clk, rst      : single clock; synchronous active-high reset
//   divider_done  : completion strobe; its rising edge starts a message (IDLE only)
//   Q_product     : unsigned 16-bit quotient
//   R_product     : 17-bit two's-complement partial remainder (bit 16 = sign)
//   divisor       : divisor used for the division
//   tx_data       : byte offered to the transmitter (0x00 when not sending)
//   tx_valid      : tx_data holds a byte
//   tx_ready      : transmitter accepts tx_data this cycle
//   busy          : high in every state except IDLE
//   fmt_done      : one-cycle pulse after the last byte is accepted
//   dbg_state_o   : current FSM state encoding
//
// Handshake: a byte transfers on every rising edge where tx_valid and
// tx_ready are both 1. While tx_valid=1 and tx_ready=0 the offered byte is
// held unchanged; tx_valid never drops until that byte has transferred.
module result_formatter (
  input  logic        clk,
  input  logic        rst,
  input  logic        divider_done,
  input  logic [15:0] Q_product,
  input  logic [16:0] R_product,
  input  logic [15:0] divisor,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        fmt_done,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_CONV_Q = 3'd2,
    S_CONV_R = 3'd3,
    S_SEND   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        done_q;
  // Cleared by reset and set once divider_done is seen low, so a strobe
  // held high across reset cannot start a message.
  logic        arm_q;
  logic [15:0] val_q, val_d;      // value being converted
  logic [15:0] rem_q, rem_d;      // corrected remainder, waits for CONV_R
  logic [3:0]  digit_q, digit_d;  // digit count for the current weight
  logic [1:0]  widx_q, widx_d;    // 0:10000 1:1000 2:100 3:10
  logic        lead_q, lead_d;    // a non-zero digit has been emitted
  logic [3:0]  len_q, len_d;      // bytes written to the message buffer
  logic [3:0]  rd_q, rd_d;        // read index while sending
  logic [7:0]  msg_q [16];
  logic [7:0]  msg_d [16];

  logic        start;
  logic [15:0] rem_corr;
  logic [15:0] weight;
  logic        emit;
  logic [3:0]  ptr, ptr1, ptr2, ptr3;

  assign start = divider_done && !done_q && arm_q;

  // Negative partial remainder gets the divisor added back (mod 2^16).
  assign rem_corr = R_product[16] ? (R_product[15:0] + divisor) : R_product[15:0];

  always_comb begin
    weight = 16'd10;
    case (widx_q)
      2'd0:    weight = 16'd10000;
      2'd1:    weight = 16'd1000;
      2'd2:    weight = 16'd100;
      default: weight = 16'd10;
    endcase
  end

  // When a weight finishes, its digit is written unless it is a leading zero.
  // ptr is where the following byte (units digit) lands after that write.
  assign emit = (digit_q != 4'd0) || lead_q;
  assign ptr  = len_q + {3'b000, emit};
  assign ptr1 = ptr + 4'd1;
  assign ptr2 = ptr + 4'd2;
  assign ptr3 = ptr + 4'd3;

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    rem_d   = rem_q;
    digit_d = digit_q;
    widx_d  = widx_q;
    lead_d  = lead_q;
    len_d   = len_q;
    rd_d    = rd_q;
    msg_d   = msg_q;

    tx_valid = 1'b0;
    tx_data  = 8'h00;
    busy     = (state_q != S_IDLE);
    fmt_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end

      S_LOAD: begin
        val_d   = Q_product;
        rem_d   = rem_corr;
        digit_d = 4'd0;
        widx_d  = 2'd0;
        lead_d  = 1'b0;
        rd_d    = 4'd0;
        if (divisor == 16'd0) begin
          msg_d[0] = 8'h45;
          msg_d[1] = 8'h52;
          msg_d[2] = 8'h52;
          msg_d[3] = 8'h0D;
          msg_d[4] = 8'h0A;
          len_d    = 4'd5;
          state_d  = S_SEND;
        end else begin
          len_d   = 4'd0;
          state_d = S_CONV_Q;
        end
      end

      S_CONV_Q, S_CONV_R: begin
        if (val_q >= weight) begin
          val_d   = val_q - weight;
          digit_d = digit_q + 4'd1;
        end else begin
          if (emit) begin
            msg_d[len_q] = 8'h30 | {4'h0, digit_q};
            lead_d       = 1'b1;
          end
          len_d   = ptr;
          digit_d = 4'd0;
          if (widx_q == 2'd3) begin
            // Residual is the units digit, always emitted.
            msg_d[ptr] = 8'h30 | {4'h0, val_q[3:0]};
            if (state_q == S_CONV_Q) begin
              msg_d[ptr1] = 8'h20;
              msg_d[ptr2] = 8'h52;
              msg_d[ptr3] = 8'h3D;
              len_d       = ptr + 4'd4;
              val_d       = rem_q;
              widx_d      = 2'd0;
              lead_d      = 1'b0;
              state_d     = S_CONV_R;
            end else begin
              msg_d[ptr1] = 8'h0D;
              msg_d[ptr2] = 8'h0A;
              len_d       = ptr3;
              rd_d        = 4'd0;
              state_d     = S_SEND;
            end
          end else begin
            widx_d = widx_q + 2'd1;
          end
        end
      end

      S_SEND: begin
        tx_valid = 1'b1;
        tx_data  = msg_q[rd_q];
        if (tx_ready) begin
          rd_d = rd_q + 4'd1;
          if (rd_q == len_q - 4'd1) state_d = S_DONE;
        end
      end

      S_DONE: begin
        fmt_done = 1'b1;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      arm_q   <= 1'b0;
      val_q   <= 16'd0;
      rem_q   <= 16'd0;
      digit_q <= 4'd0;
      widx_q  <= 2'd0;
      lead_q  <= 1'b0;
      len_q   <= 4'd0;
      rd_q    <= 4'd0;
      for (int i = 0; i < 16; i++) msg_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      done_q  <= divider_done;
      if (!divider_done) arm_q <= 1'b1;
      val_q   <= val_d;
      rem_q   <= rem_d;
      digit_q <= digit_d;
      widx_q  <= widx_d;
      lead_q  <= lead_d;
      len_q   <= len_d;
      rd_q    <= rd_d;
      msg_q   <= msg_d;
    end
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_result_formatter.sv
module tb_result_formatter;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        divider_done = 1'b0;
  logic [15:0] Q_product = 16'd0;
  logic [16:0] R_product = 17'd0;
  logic [15:0] divisor = 16'd0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy;
  logic        fmt_done;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  result_formatter dut (
    .clk          (clk),
    .rst          (rst),
    .divider_done (divider_done),
    .Q_product    (Q_product),
    .R_product    (R_product),
    .divisor      (divisor),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .fmt_done     (fmt_done),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the line is just "<q> R=<rem>\r\n" in decimal text.
  task automatic build_expected(input logic [15:0] q, input logic [16:0] r, input logic [15:0] d);
    string s;
    int    rem;
    exp_q.delete();
    if (d == 16'd0) begin
      s = "ERR";
    end else begin
      rem = r[16] ? ((int'(r[15:0]) + int'(d)) % 65536) : int'(r[15:0]);
      s   = $sformatf("%0d R=%0d", q, rem);
    end
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // ---------------- driver ----------------
  task automatic do_reset();
    rst = 1'b1;
    divider_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // mode 0: ready always 1     mode 1: random ready
  // mode 2: ready low 3 cycles while byte 2 is offered
  // mode 3: extra divider_done edge while busy
  // mode 4: reset after 3 bytes  mode 5: reset during conversion
  task automatic run_case(input logic [15:0] q, input logic [16:0] r, input logic [15:0] d,
                          input int mode, input string tag);
    int n, cyc, got, first_valid, stall, fmt_cnt, quiet;
    logic       holding;
    logic [7:0] held;
    build_expected(q, r, d);
    n = exp_q.size();
    @(posedge clk); #1;
    Q_product = q; R_product = r; divisor = d;
    divider_done = 1'b1;
    tx_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    cyc = 0; got = 0; first_valid = -1; stall = 0; fmt_cnt = 0; holding = 1'b0; held = 8'h00;
    @(posedge clk); #1 divider_done = 1'b0;
    while (cyc < 400 && fmt_cnt == 0) begin
      @(negedge clk);
      if (tx_valid && first_valid < 0) first_valid = cyc;
      if (holding && tx_valid) chk({tag, " hold_stable"}, tx_data, held);
      if (mode == 2 && tx_valid && !tx_ready) chk({tag, " stall_byte"}, tx_data, 8'h20);
      holding = tx_valid && !tx_ready;
      held = tx_data;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) chk({tag, " extra_byte"}, got, n);
        else chk($sformatf("%s byte%0d", tag, got), tx_data, exp_q.pop_front());
        got++;
      end
      if (fmt_done) begin
        fmt_cnt++;
        chk({tag, " fmt_valid_low"}, tx_valid, 1'b0);
      end
      @(posedge clk); #1;
      cyc++;
      if ((mode == 4 && got == 3) || (mode == 5 && cyc == 3)) begin
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk({tag, " rst_valid"}, tx_valid, 1'b0);
        chk({tag, " rst_busy"}, busy, 1'b0);
        chk({tag, " rst_fmt"}, fmt_done, 1'b0);
        quiet = 0;
        repeat (10) begin
          @(negedge clk);
          if (tx_valid || fmt_done || busy) quiet++;
        end
        chk({tag, " rst_quiet"}, quiet, 0);
        return;
      end
      case (mode)
        1: tx_ready = 1'($urandom_range(0, 1));
        2: begin
          if (got == 2 && stall < 3) begin
            tx_ready = 1'b0;
            stall++;
          end else begin
            tx_ready = 1'b1;
          end
        end
        3: begin
          if (cyc == 5) divider_done = 1'b1;
          if (cyc == 7) divider_done = 1'b0;
        end
        default: tx_ready = 1'b1;
      endcase
    end
    chk({tag, " fmt_seen"}, fmt_cnt, 1);
    chk({tag, " byte_count"}, got, n);
    chk({tag, " first_valid_lat"}, (first_valid >= 0 && first_valid < 100), 1'b1);
    @(negedge clk);
    chk({tag, " fmt_one_cycle"}, fmt_done, 1'b0);
    chk({tag, " idle_busy"}, busy, 1'b0);
    if (mode == 3) begin
      quiet = 0;
      repeat (5) begin
        @(negedge clk);
        if (busy) quiet++;
      end
      chk({tag, " ghost_ignored"}, quiet, 0);
    end
    tx_ready = 1'b1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int seen;
    logic [15:0] rq, rd;
    logic [16:0] rr;

    do_reset();
    @(negedge clk);
    chk("reset tx_valid", tx_valid, 1'b0);
    chk("reset tx_data", tx_data, 8'h00);
    chk("reset busy", busy, 1'b0);
    chk("reset fmt_done", fmt_done, 1'b0);

    run_case(16'd14, 17'h00002, 16'd7, 0, "q14r2");
    run_case(16'd14, 17'h1FFFB, 16'd7, 0, "q14neg");
    run_case(16'd0, 17'd5, 16'd9, 0, "q0");
    run_case(16'd65535, 17'd0, 16'd1, 0, "qmax");
    run_case(16'd1234, 17'h1ABCD, 16'd0, 0, "err");
    run_case(16'd14, 17'h00002, 16'd7, 2, "stall");
    run_case(16'd14, 17'h00002, 16'd7, 3, "ghost");
    run_case(16'd14, 17'h00002, 16'd7, 4, "rst_send");
    run_case(16'd9999, 17'd42, 16'd100, 5, "rst_conv");

    // divider_done held high across reset must not start a message
    @(posedge clk); #1;
    divider_done = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy) seen++;
    end
    chk("held_done_no_start", seen, 0);
    @(posedge clk); #1 divider_done = 1'b0;

    run_case(16'd10000, 17'd10, 16'd60000, 0, "zeros_mid");

    for (int i = 0; i < 12; i++) begin
      rq = 16'($urandom_range(0, 65535));
      rr = 17'($urandom);
      rd = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
      run_case(rq, rr, rd, 1, $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
